// File: rtl/ysyx_24080006_icache_refill.sv
// Refills one icache line from AXI with a single burst and writes it to the icache array.
// Optional YSYX_24080006_ICACHE_CWF_EN: critical-word-first WRAP burst starting at the missed word.
package ysyx_24080006_icache_pkg;
  localparam int IcacheLineSize = 5;
  localparam int IcacheLineNum  = 1;
  localparam int IcacheBeats    = 1 << (IcacheLineSize - 2);
  localparam int IcacheTagW     = 32 - IcacheLineSize - IcacheLineNum;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

  typedef struct packed {
    logic                        valid;
    logic [IcacheTagW-1:0]       tag;
    logic [IcacheBeats*32-1:0]   data;
  } icache_t;
endpackage

module ysyx_24080006_icache_refill
  import ysyx_24080006_icache_pkg::*;
#(
  parameter int LINE_SIZE = IcacheLineSize,
  parameter int LINE_NUM  = IcacheLineNum
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [31:0]         req_addr,
  output logic                req_ready,
  input  logic                flush,
  output logic                busy,
  output axi_r_m2s_t          axi_r_o,
  input  axi_r_s2m_t          axi_r_i,
  output logic                fill_we,
  output logic [LINE_NUM-1:0] fill_index,
  output icache_t             fill_line,
  output logic                crit_valid,
  output logic [31:0]         crit_data,
  output logic                proto_err
);

  localparam int N      = 1 << (LINE_SIZE - 2);
  localparam int CW     = LINE_SIZE - 2;
  localparam int TAG_LO = LINE_SIZE + LINE_NUM;
`ifdef YSYX_24080006_ICACHE_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:2]     addr_q;
  logic            kill_q, kill_d;
  logic [CW-1:0]   cnt_q;
  logic [N*32-1:0] data_q;
  logic            crit_valid_q;
  logic [31:0]     crit_data_q;
  logic            proto_err_q;

  logic [CW-1:0]   offs;
  logic [CW-1:0]   slot;
  logic            accept, beat_fire, last_beat, beat_err, crit_hit;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = ^req_addr[1:0];

  // cnt_q counts beats; slot is where the current beat lands in the line
  assign offs      = addr_q[LINE_SIZE-1:2];
  assign slot      = CWF ? cnt_q + offs : cnt_q;
  assign accept    = (state_q == IDLE) && req_valid && !flush;
  assign beat_fire = (state_q == R) && axi_r_i.rvalid;
  assign last_beat = (cnt_q == CW'(N - 1));
  assign beat_err  = beat_fire && (axi_r_i.rlast != last_beat);
  assign crit_hit  = beat_fire && (slot == offs) && !kill_d;

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = AR;
        kill_d  = 1'b0;
      end
      AR: begin
        if (flush) kill_d = 1'b1;
        if (axi_r_i.arready) state_d = R;
      end
      R: begin
        if (flush || beat_err) kill_d = 1'b1;
        if (beat_fire && axi_r_i.rlast) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_r_o = '0;
    if (state_q == AR) begin
      axi_r_o.arvalid = 1'b1;
      axi_r_o.araddr  = CWF ? {addr_q, 2'b00} : {addr_q[31:LINE_SIZE], {LINE_SIZE{1'b0}}};
      axi_r_o.arlen   = 8'(N - 1);
      axi_r_o.arsize  = 3'b010;
      axi_r_o.arburst = CWF ? 2'b10 : 2'b01;
    end
    axi_r_o.rready = (state_q == R);
  end

  always_comb begin
    fill_line       = '0;
    fill_line.valid = (state_q == DONE);
    fill_line.tag   = addr_q[31:TAG_LO];
    fill_line.data  = data_q;
  end

  assign req_ready  = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign fill_we    = (state_q == DONE) && !kill_q && !flush;
  assign fill_index = addr_q[TAG_LO-1:LINE_SIZE];
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign proto_err  = proto_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      kill_q       <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      crit_valid_q <= crit_hit;
      proto_err_q  <= beat_err;
      if (accept) begin
        addr_q <= req_addr[31:2];
        cnt_q  <= '0;
      end
      if (beat_fire) begin
        data_q[{slot, 5'd0} +: 32] <= axi_r_i.rdata;
        cnt_q                      <= cnt_q + CW'(1);
      end
      if (crit_hit) crit_data_q <= axi_r_i.rdata;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_icache_refill.sv
// Bench for the icache refill engine: table vectors, hand sequences and random bursts vs a line-level model.
module tb_ysyx_24080006_icache_refill;
  import ysyx_24080006_icache_pkg::*;

`ifdef YSYX_24080006_ICACHE_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clock, reset, req_valid, req_ready, flush, busy;
  logic [31:0] req_addr;
  axi_r_m2s_t  axi_r_o;
  axi_r_s2m_t  axi_r_i;
  logic        fill_we, crit_valid, proto_err;
  logic [0:0]  fill_index;
  icache_t     fill_line;
  logic [31:0] crit_data;

  int vectors = 0;
  int fails   = 0;

  ysyx_24080006_icache_refill dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .busy(busy), .axi_r_o(axi_r_o),
    .axi_r_i(axi_r_i), .fill_we(fill_we), .fill_index(fill_index),
    .fill_line(fill_line), .crit_valid(crit_valid), .crit_data(crit_data),
    .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // fl_beat: -1 none, >=0 flush while that beat is accepted, -2 flush during the fill cycle
  typedef struct {
    logic [31:0] addr;
    int ar_dly;
    int gap;
    int nb;
    int fl_beat;
    int e_fill;
    int e_proto;
    int e_crit;
  } vec_t;

  task automatic run_txn(input vec_t v, input bit use_exp, input string nm);
    int w, base, ci, nerr, first_err, c, k, ar_seen, gap_cnt, done_c;
    int fill_n, crit_n, proto_n, fill_c, crit_c, proto_c, ar_first, ar_bad, rr_bad, rq_bad;
    int e_fill, e_proto, e_crit;
    bit ar_done, fin;
    logic [31:0] slot_data [8];
    logic [255:0] line_d;
    int beat_c [$];
    icache_t fl_line, exp_line;
    logic [0:0] fl_idx;
    logic [31:0] crit_d;
    axi_r_m2s_t exp_ar;

    w = int'(v.addr[4:2]);
    base = CWF ? w : 0;
    for (int s = 0; s < 8; s++) slot_data[s] = use_exp ? 32'h1000 + s : $urandom;
    exp_ar = '0;
    exp_ar.arvalid = 1'b1;
    exp_ar.araddr  = CWF ? {v.addr[31:2], 2'b00} : {v.addr[31:5], 5'b0};
    exp_ar.arlen   = 8'd7;
    exp_ar.arsize  = 3'b010;
    exp_ar.arburst = CWF ? 2'b10 : 2'b01;
    k = 0; ar_seen = 0; gap_cnt = 0; done_c = -1; ar_done = 0; fin = 0;
    fill_n = 0; crit_n = 0; proto_n = 0; fill_c = -1; crit_c = -1; proto_c = -1;
    ar_first = -1; ar_bad = 0; rr_bad = 0; rq_bad = 0;
    fl_line = '0; fl_idx = '0; crit_d = '0;

    req_valid = 1'b1; req_addr = v.addr; flush = 1'b0; axi_r_i = '0;
    @(negedge clock);
    chk({nm, "_req_ready"}, req_ready, 1);
    @(posedge clock); #1;
    c = 1;
    while (!fin && c < 400) begin
      req_valid = (done_c >= 0) ? 1'b0 : 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      flush     = 1'b0;
      axi_r_i   = '0;
      if (!ar_done) axi_r_i.arready = (ar_seen >= v.ar_dly);
      else if (k < v.nb && gap_cnt == 0) begin
        axi_r_i.rvalid = 1'b1;
        axi_r_i.rdata  = slot_data[(base + k) % 8];
        axi_r_i.rlast  = (k == v.nb - 1);
        if (k == v.fl_beat) flush = 1'b1;
      end
      if (v.fl_beat == -2 && done_c == c) flush = 1'b1;
      @(negedge clock);
      if (axi_r_o.arvalid) begin
        if (ar_first < 0) ar_first = c;
        if (axi_r_o !== exp_ar) ar_bad++;
      end
      if (ar_done && done_c < 0 && !axi_r_o.rready) rr_bad++;
      if ((done_c < 0 || c <= done_c) && req_ready) rq_bad++;
      if (fill_we) begin fill_n++; fill_c = c; fl_line = fill_line; fl_idx = fill_index; end
      if (crit_valid) begin
        crit_n++;
        if (crit_n == 1) begin crit_c = c; crit_d = crit_data; end
      end
      if (proto_err) begin proto_n++; if (proto_c < 0) proto_c = c; end
      if (c == done_c + 1 && done_c >= 0) begin
        chk({nm, "_ready_after"}, req_ready, 1);
        chk({nm, "_idle_after"}, busy, 0);
        fin = 1;
      end
      if (axi_r_i.rvalid && axi_r_o.rready) begin
        beat_c.push_back(c);
        if (axi_r_i.rlast) done_c = c + 1;
        k++;
        gap_cnt = (v.gap >= 0) ? v.gap : $urandom_range(0, -v.gap);
      end else if (ar_done && !axi_r_i.rvalid && gap_cnt > 0) gap_cnt--;
      if (axi_r_o.arvalid) begin
        if (axi_r_i.arready) ar_done = 1;
        ar_seen++;
      end
      @(posedge clock); #1;
      c++;
    end
    req_valid = 1'b0; flush = 1'b0; axi_r_i = '0;
    chk({nm, "_completed"}, fin, 1);

    nerr = 0; first_err = -1;
    for (int i = 0; i < v.nb; i++)
      if ((i == v.nb - 1) != (i % 8 == 7)) begin
        nerr++;
        if (first_err < 0) first_err = i;
      end
    ci = CWF ? 0 : w;
    e_fill  = use_exp ? v.e_fill  : int'(v.fl_beat == -1 && nerr == 0);
    e_proto = use_exp ? v.e_proto : nerr;
    e_crit  = use_exp ? v.e_crit  : int'(ci < v.nb && (v.fl_beat < 0 || v.fl_beat > ci) &&
                                         (first_err < 0 || first_err > ci));
    chk({nm, "_beats"}, beat_c.size(), v.nb);
    chk({nm, "_fill_count"}, fill_n, e_fill);
    chk({nm, "_proto_count"}, proto_n, e_proto);
    chk({nm, "_crit_count"}, crit_n, e_crit);
    chk({nm, "_ar_first_cycle"}, ar_first, 1);
    chk({nm, "_ar_fields"}, ar_bad, 0);
    chk({nm, "_rready_held"}, rr_bad, 0);
    chk({nm, "_ready_while_busy"}, rq_bad, 0);
    if (e_fill == 1 && fill_n == 1 && beat_c.size() == v.nb) begin
      for (int s = 0; s < 8; s++) line_d[s*32 +: 32] = slot_data[s];
      exp_line = '{valid: 1'b1, tag: v.addr[31:6], data: line_d};
      chk({nm, "_fill_cycle"}, fill_c, beat_c[v.nb-1] + 1);
      chk({nm, "_fill_line"}, fl_line, exp_line);
      chk({nm, "_fill_index"}, fl_idx, v.addr[5]);
      if (v.ar_dly == 0 && v.gap == 0) chk({nm, "_fill_latency"}, fill_c, 10);
    end
    if (e_crit == 1 && crit_n >= 1 && ci < beat_c.size()) begin
      chk({nm, "_crit_cycle"}, crit_c, beat_c[ci] + 1);
      chk({nm, "_crit_data"}, crit_d, slot_data[w]);
    end
    if (nerr > 0 && proto_n > 0 && first_err < beat_c.size())
      chk({nm, "_proto_cycle"}, proto_c, beat_c[first_err] + 1);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    tbl[0] = '{32'h3000_0014, 0,  0,  8, -1, 1, 0, 1};
    tbl[1] = '{32'h3000_0014, 3,  2,  8, -1, 1, 0, 1};
    tbl[2] = '{32'h3000_0014, 0,  0,  8,  3, 0, 0, int'(CWF)};
    tbl[3] = '{32'h3000_0014, 0,  0,  6, -1, 0, 1, int'(CWF)};
    tbl[4] = '{32'h3000_0014, 0,  0, 16, -1, 0, 1, 1};
    tbl[5] = '{32'h3000_0020, 1,  1,  8, -2, 0, 0, 1};
    tbl[6] = '{32'h8000_001C, 0,  0,  8, -1, 1, 0, 1};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; axi_r_i = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_axi_o", axi_r_o, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_fill_line", fill_line, 0);
    chk("rst_fill_index", fill_index, 0);
    chk("rst_crit", {crit_valid, crit_data}, 0);
    chk("rst_proto_err", proto_err, 0);
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // flush while idle blocks acceptance
    req_valid = 1'b1; req_addr = 32'h4000_0000; flush = 1'b1;
    @(negedge clock);
    chk("flush_idle_ready", req_ready, 0);
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("flush_idle_busy", busy, 0);
    @(posedge clock); #1;

    // reset in the middle of a burst
    req_valid = 1'b1; req_addr = 32'h1234_5678;
    @(posedge clock); #1;
    req_valid = 1'b0; axi_r_i.arready = 1'b1;
    @(posedge clock); #1;
    axi_r_i = '0; axi_r_i.rvalid = 1'b1; axi_r_i.rdata = 32'hdead_beef;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; axi_r_i = '0;
    @(negedge clock);
    chk("midrst_busy", busy, 0);
    chk("midrst_axi_o", axi_r_o, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_outs", {fill_we, crit_valid, proto_err}, 0);
    @(posedge clock); #1;

    for (int i = 0; i < 20; i++) begin
      rv.addr    = $urandom;
      rv.ar_dly  = $urandom_range(0, 3);
      rv.gap     = -int'($urandom_range(0, 2));
      rv.nb      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 12)) : 8;
      rv.fl_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rv.nb - 1)) : -1;
      rv.e_fill = 0; rv.e_proto = 0; rv.e_crit = 0;
      run_txn(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
